// File: rtl/oob_dev.sv
// oob_dev: device-side SATA OOB responder.
// Answers a host COMRESET with COMINIT, waits for the host COMWAKE, answers
// with COMWAKE, then runs the ALIGN/SYNC handshake and declares the link up.
// Everything runs in the sata (usrclk2) clock domain.
module oob_dev #(
    parameter int          DATA_BYTE_WIDTH = 4,          // only 4 is supported
    parameter logic [19:0] COMWAKE_TIMEOUT = 20'd66000,
    parameter logic [19:0] ALIGN_TIMEOUT   = 20'd66000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         gtx_ready,
    input  logic                         rxcominitdet_in,
    input  logic                         rxcomwakedet_in,
    input  logic                         rxelecidle_in,
    input  logic                         txcomfinish,
    output logic                         txcominit,
    output logic                         txcomwake,
    output logic                         txelecidle,
    input  logic [DATA_BYTE_WIDTH*8-1:0] txdata_in,
    input  logic [DATA_BYTE_WIDTH-1:0]   txcharisk_in,
    output logic [DATA_BYTE_WIDTH*8-1:0] txdata_out,
    output logic [DATA_BYTE_WIDTH-1:0]   txcharisk_out,
    input  logic [DATA_BYTE_WIDTH*8-1:0] rxdata_in,
    input  logic [DATA_BYTE_WIDTH-1:0]   rxcharisk_in,
    input  logic                         rxbyteisaligned,
    output logic                         dev_reset,
    output logic                         phy_ready
);

    localparam logic [31:0] ALIGN_WORD = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC_WORD  = 32'hB5B5957C;
    localparam logic [3:0]  PRIM_K     = 4'b0001;

    localparam logic [3:0] ST_IDLE          = 4'd0;
    localparam logic [3:0] ST_COMINIT       = 4'd1;
    localparam logic [3:0] ST_WAIT_CINIT    = 4'd2;
    localparam logic [3:0] ST_WAIT_WAKE     = 4'd3;
    localparam logic [3:0] ST_WAIT_WAKE_END = 4'd4;
    localparam logic [3:0] ST_COMWAKE       = 4'd5;
    localparam logic [3:0] ST_WAIT_CWAKE    = 4'd6;
    localparam logic [3:0] ST_SEND_ALIGN    = 4'd7;
    localparam logic [3:0] ST_SEND_SYNC     = 4'd8;
    localparam logic [3:0] ST_READY         = 4'd9;
    localparam logic [3:0] ST_ERROR         = 4'd10;

    logic [3:0]  state;
    logic [3:0]  next_state;
    logic [19:0] timer;
    logic [1:0]  sync_cnt;
    logic        rx_align;
    logic        rx_sync_like;
    logic        cominit_ok;

    // Host electrical idle is not needed by this responder; COMWAKE detect
    // already covers the end of the wake burst.
    logic unused_ok;
    assign unused_ok = rxelecidle_in;

    // Classify the current rx word for the handshake states.
    always_comb begin
        rx_align     = rxbyteisaligned && (rxdata_in == ALIGN_WORD) && (rxcharisk_in == PRIM_K);
        rx_sync_like = rxcharisk_in[0] && (rxdata_in != ALIGN_WORD);
        // While our own COMINIT is being issued a COMRESET detect is the
        // echo of the host burst, so it must not restart the sequence.
        cominit_ok   = rxcominitdet_in && (state != ST_COMINIT) && (state != ST_WAIT_CINIT);
    end

    // Next-state logic: gtx_ready loss, then COMRESET, then normal flow.
    always_comb begin
        next_state = state;
        if (!gtx_ready) begin
            next_state = ST_IDLE;
        end else if (cominit_ok) begin
            next_state = ST_COMINIT;
        end else begin
            case (state)
                ST_IDLE:          next_state = ST_IDLE;
                ST_COMINIT:       next_state = ST_WAIT_CINIT;
                ST_WAIT_CINIT:    next_state = txcomfinish ? ST_WAIT_WAKE : ST_WAIT_CINIT;
                ST_WAIT_WAKE: begin
                    if (rxcomwakedet_in) begin
                        next_state = ST_WAIT_WAKE_END;
                    end else if (timer == COMWAKE_TIMEOUT) begin
                        next_state = ST_ERROR;
                    end else begin
                        next_state = ST_WAIT_WAKE;
                    end
                end
                ST_WAIT_WAKE_END: next_state = rxcomwakedet_in ? ST_WAIT_WAKE_END : ST_COMWAKE;
                ST_COMWAKE:       next_state = ST_WAIT_CWAKE;
                ST_WAIT_CWAKE:    next_state = txcomfinish ? ST_SEND_ALIGN : ST_WAIT_CWAKE;
                ST_SEND_ALIGN: begin
                    if (rx_align) begin
                        next_state = ST_SEND_SYNC;
                    end else if (timer == ALIGN_TIMEOUT) begin
                        next_state = ST_ERROR;
                    end else begin
                        next_state = ST_SEND_ALIGN;
                    end
                end
                ST_SEND_SYNC: begin
                    if (rx_sync_like && (sync_cnt == 2'd2)) begin
                        next_state = ST_READY;
                    end else begin
                        next_state = ST_SEND_SYNC;
                    end
                end
                ST_READY:         next_state = ST_READY;
                ST_ERROR:         next_state = ST_IDLE;
                default:          next_state = ST_IDLE;
            endcase
        end
    end

    // State register, handshake timer and SYNC run counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            timer    <= 20'd0;
            sync_cnt <= 2'd0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                timer <= 20'd0;
            end else if (((state == ST_WAIT_WAKE) || (state == ST_SEND_ALIGN)) && (timer != 20'hFFFFF)) begin
                timer <= timer + 20'd1;
            end else begin
                timer <= timer;
            end
            if ((state == ST_SEND_SYNC) && (next_state == ST_SEND_SYNC) && rx_sync_like) begin
                sync_cnt <= sync_cnt + 2'd1;
            end else begin
                sync_cnt <= 2'd0;
            end
        end
    end

    // Registered tx stream and dev_reset pulse, both aligned to the state
    // being entered so the stream matches the state one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            txdata_out    <= 32'd0;
            txcharisk_out <= 4'd0;
            dev_reset     <= 1'b0;
        end else begin
            dev_reset <= (next_state == ST_COMINIT);
            case (next_state)
                ST_SEND_ALIGN: begin
                    txdata_out    <= ALIGN_WORD;
                    txcharisk_out <= PRIM_K;
                end
                ST_SEND_SYNC: begin
                    txdata_out    <= SYNC_WORD;
                    txcharisk_out <= PRIM_K;
                end
                ST_READY: begin
                    txdata_out    <= txdata_in;
                    txcharisk_out <= txcharisk_in;
                end
                default: begin
                    txdata_out    <= 32'd0;
                    txcharisk_out <= 4'd0;
                end
            endcase
        end
    end

    // Moore decode of the control outputs from the state register.
    always_comb begin
        txcominit  = 1'b0;
        txcomwake  = 1'b0;
        txelecidle = 1'b1;
        phy_ready  = 1'b0;
        case (state)
            ST_COMINIT:    txcominit  = 1'b1;
            ST_COMWAKE:    txcomwake  = 1'b1;
            ST_SEND_ALIGN: txelecidle = 1'b0;
            ST_SEND_SYNC:  txelecidle = 1'b0;
            ST_READY: begin
                txelecidle = 1'b0;
                phy_ready  = 1'b1;
            end
            default: txelecidle = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_oob_dev.sv
// Directed testbench for oob_dev with shortened handshake timeouts.
module tb_oob_dev;

    localparam logic [19:0] WAKE_TO  = 20'd200;
    localparam logic [19:0] ALIGN_TO = 20'd150;
    localparam logic [31:0] ALIGN_W  = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC_W   = 32'hB5B5957C;

    logic        clk = 1'b0;
    logic        rst;
    logic        gtx_ready;
    logic        rxcominitdet_in;
    logic        rxcomwakedet_in;
    logic        rxelecidle_in;
    logic        txcomfinish;
    logic        txcominit;
    logic        txcomwake;
    logic        txelecidle;
    logic [31:0] txdata_in;
    logic [3:0]  txcharisk_in;
    logic [31:0] txdata_out;
    logic [3:0]  txcharisk_out;
    logic [31:0] rxdata_in;
    logic [3:0]  rxcharisk_in;
    logic        rxbyteisaligned;
    logic        dev_reset;
    logic        phy_ready;

    int vectors = 0;
    int miscompares = 0;

    oob_dev #(
        .DATA_BYTE_WIDTH(4),
        .COMWAKE_TIMEOUT(WAKE_TO),
        .ALIGN_TIMEOUT(ALIGN_TO)
    ) dut (
        .clk(clk), .rst(rst), .gtx_ready(gtx_ready),
        .rxcominitdet_in(rxcominitdet_in), .rxcomwakedet_in(rxcomwakedet_in),
        .rxelecidle_in(rxelecidle_in), .txcomfinish(txcomfinish),
        .txcominit(txcominit), .txcomwake(txcomwake), .txelecidle(txelecidle),
        .txdata_in(txdata_in), .txcharisk_in(txcharisk_in),
        .txdata_out(txdata_out), .txcharisk_out(txcharisk_out),
        .rxdata_in(rxdata_in), .rxcharisk_in(rxcharisk_in),
        .rxbyteisaligned(rxbyteisaligned), .dev_reset(dev_reset), .phy_ready(phy_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input logic [31:0] d, input logic [3:0] k);
        rxdata_in    = d;
        rxcharisk_in = k;
    endtask

    // From any state: COMRESET through to SEND_ALIGN with minimal delays.
    task automatic goto_send_align();
        set_rx(32'd0, 4'd0);
        rxcominitdet_in = 1'b1; tick(); rxcominitdet_in = 1'b0;
        tick();
        txcomfinish = 1'b1; tick(); txcomfinish = 1'b0;
        rxcomwakedet_in = 1'b1; tick(); rxcomwakedet_in = 1'b0;
        tick();
        tick();
        txcomfinish = 1'b1; tick(); txcomfinish = 1'b0;
    endtask

    initial begin
        int dev_cnt;
        int cinit_cnt;
        int ready_seen;
        rst = 1'b1; gtx_ready = 1'b1;
        rxcominitdet_in = 1'b0; rxcomwakedet_in = 1'b0; rxelecidle_in = 1'b1;
        txcomfinish = 1'b0; txdata_in = 32'd0; txcharisk_in = 4'd0;
        rxbyteisaligned = 1'b1; set_rx(32'd0, 4'd0);
        tick(); tick(); tick();
        chk("rst_txelecidle", {31'd0, txelecidle}, 32'd1);
        chk("rst_txcominit",  {31'd0, txcominit},  32'd0);
        chk("rst_txcomwake",  {31'd0, txcomwake},  32'd0);
        chk("rst_dev_reset",  {31'd0, dev_reset},  32'd0);
        chk("rst_phy_ready",  {31'd0, phy_ready},  32'd0);
        chk("rst_txdata",     txdata_out,          32'd0);
        chk("rst_txcharisk",  {28'd0, txcharisk_out}, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_txelecidle", {31'd0, txelecidle}, 32'd1);

        // ---- normal bring-up ----
        rxcominitdet_in = 1'b1; tick(); rxcominitdet_in = 1'b0;
        chk("up_dev_reset", {31'd0, dev_reset}, 32'd1);
        chk("up_txcominit", {31'd0, txcominit}, 32'd1);
        dev_cnt = 0; cinit_cnt = 0;
        for (int i = 0; i < 19; i++) begin
            tick();
            dev_cnt   += int'(dev_reset);
            cinit_cnt += int'(txcominit);
        end
        chk("up_dev_reset_once", dev_cnt,   32'd0);
        chk("up_cominit_once",   cinit_cnt, 32'd0);
        txcomfinish = 1'b1; tick(); txcomfinish = 1'b0;
        rxcomwakedet_in = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("up_no_early_wake", {31'd0, txcomwake}, 32'd0);
        rxcomwakedet_in = 1'b0; tick();
        chk("up_txcomwake",  {31'd0, txcomwake},  32'd1);
        chk("up_wake_eidle", {31'd0, txelecidle}, 32'd1);
        tick();
        chk("up_txcomwake_1cyc", {31'd0, txcomwake}, 32'd0);
        txcomfinish = 1'b1; tick(); txcomfinish = 1'b0;
        chk("up_align_eidle", {31'd0, txelecidle}, 32'd0);
        chk("up_align_data",  txdata_out, ALIGN_W);
        chk("up_align_k",     {28'd0, txcharisk_out}, 32'd1);
        tick(); tick();
        chk("up_align_hold",  txdata_out, ALIGN_W);
        set_rx(ALIGN_W, 4'b0001); tick();
        chk("up_sync_data", txdata_out, SYNC_W);
        chk("up_sync_k",    {28'd0, txcharisk_out}, 32'd1);
        set_rx(SYNC_W, 4'b0001);
        tick(); tick();
        chk("up_not_ready_2sync", {31'd0, phy_ready}, 32'd0);
        tick();
        chk("up_phy_ready", {31'd0, phy_ready}, 32'd1);
        chk("up_ready_first_data", txdata_out, 32'd0);
        txdata_in = 32'h12345678; txcharisk_in = 4'b0010; tick();
        chk("up_pass_data", txdata_out, 32'h12345678);
        chk("up_pass_k",    {28'd0, txcharisk_out}, 32'd2);
        chk("up_ready_eidle", {31'd0, txelecidle}, 32'd0);

        // ---- COMRESET in READY ----
        rxcominitdet_in = 1'b1; tick(); rxcominitdet_in = 1'b0;
        chk("cr_phy_ready", {31'd0, phy_ready},  32'd0);
        chk("cr_eidle",     {31'd0, txelecidle}, 32'd1);
        chk("cr_dev_reset", {31'd0, dev_reset},  32'd1);
        chk("cr_txcominit", {31'd0, txcominit},  32'd1);
        chk("cr_txdata",    txdata_out, 32'd0);
        tick();
        chk("cr_dev_reset_1cyc", {31'd0, dev_reset}, 32'd0);

        // ---- COMWAKE timeout ----
        set_rx(32'd0, 4'd0);
        txcomfinish = 1'b1; tick(); txcomfinish = 1'b0;
        ready_seen = 0;
        for (int i = 0; i < int'(WAKE_TO); i++) begin
            tick();
            ready_seen += int'(phy_ready) + int'(!txelecidle);
        end
        tick();
        ready_seen += int'(phy_ready) + int'(!txelecidle);
        chk("wto_eidle_ready_never", ready_seen, 32'd0);
        // Already past the timeout: a late COMWAKE must not be answered.
        rxcomwakedet_in = 1'b1; tick(); rxcomwakedet_in = 1'b0; tick();
        chk("wto_late_wake_ignored", {31'd0, txcomwake}, 32'd0);
        tick();
        chk("wto_late_wake_ignored2", {31'd0, txcomwake}, 32'd0);

        // ---- COMWAKE at the last cycle before timeout is still accepted ----
        rxcominitdet_in = 1'b1; tick(); rxcominitdet_in = 1'b0;
        chk("wb_dev_reset", {31'd0, dev_reset}, 32'd1);
        tick();
        txcomfinish = 1'b1; tick(); txcomfinish = 1'b0;
        for (int i = 0; i < int'(WAKE_TO); i++) tick();
        rxcomwakedet_in = 1'b1; tick(); rxcomwakedet_in = 1'b0; tick();
        chk("wb_boundary_wake", {31'd0, txcomwake}, 32'd1);
        tick();
        txcomfinish = 1'b1; tick(); txcomfinish = 1'b0;

        // ---- ALIGN timeout ----
        set_rx(32'h4A4A4A4A, 4'd0);
        ready_seen = 0;
        for (int i = 0; i < int'(ALIGN_TO); i++) begin
            tick();
            ready_seen += int'(txelecidle) + int'(txdata_out != ALIGN_W);
        end
        chk("ato_align_held", ready_seen, 32'd0);
        tick();
        chk("ato_eidle",  {31'd0, txelecidle}, 32'd1);
        chk("ato_txdata", txdata_out, 32'd0);
        chk("ato_no_ready", {31'd0, phy_ready}, 32'd0);
        tick();
        chk("ato_idle_eidle", {31'd0, txelecidle}, 32'd1);

        // ---- SYNC count reset ----
        goto_send_align();
        chk("sc_in_align", txdata_out, ALIGN_W);
        set_rx(ALIGN_W, 4'b0001); tick();
        set_rx(SYNC_W, 4'b0001); tick(); tick();
        set_rx(ALIGN_W, 4'b0001); tick();
        chk("sc_after_align", {31'd0, phy_ready}, 32'd0);
        set_rx(SYNC_W, 4'b0001); tick(); tick();
        chk("sc_two_after_reset", {31'd0, phy_ready}, 32'd0);
        tick();
        chk("sc_ready", {31'd0, phy_ready}, 32'd1);

        // ---- gtx_ready drop in SEND_ALIGN ----
        goto_send_align();
        chk("gd_in_align", {31'd0, txelecidle}, 32'd0);
        gtx_ready = 1'b0; tick();
        chk("gd_eidle",     {31'd0, txelecidle}, 32'd1);
        chk("gd_dev_reset", {31'd0, dev_reset},  32'd0);
        chk("gd_txdata",    txdata_out, 32'd0);
        gtx_ready = 1'b1; tick();
        chk("gd_idle_eidle", {31'd0, txelecidle}, 32'd1);
        chk("gd_idle_dev_reset", {31'd0, dev_reset}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/oob_dev.md
Name: oob_dev

Overview:
- Device-side SATA OOB responder: the opposite end of the host OOB controller, used for the loopback or device-emulation build of the PHY.
- Detects host COMRESET, answers with COMINIT, waits for host COMWAKE, answers with COMWAKE, then performs the ALIGN/SYNC handshake and declares the link up.
- Sits between the GTX wrapper (OOB detect/issue pins, 32-bit rx/tx stream) and the device link layer.
- Runs in the usrclk2 (sata clk) domain.

Parameters:
DATA_BYTE_WIDTH, 4, stream width in bytes; only 4 is supported.
COMWAKE_TIMEOUT, 20'd66000, clk cycles to wait for host COMWAKE (~880 us at 75 MHz).
ALIGN_TIMEOUT, 20'd66000, clk cycles to wait for host ALIGN after starting to transmit ALIGN.

Ports:
clk  in  1  sata clk (usrclk2).
rst  in  1  reset.
gtx_ready  in  1  all GTX resets done.
rxcominitdet_in  in  1  GTX COMRESET/COMINIT detect.
rxcomwakedet_in  in  1  GTX COMWAKE detect (level while pattern is present).
rxelecidle_in  in  1  rx electrical idle.
txcomfinish  in  1  GTX 1-cycle pulse: OOB burst sequence sent.
txcominit  out  1  issue COMINIT.
txcomwake  out  1  issue COMWAKE.
txelecidle  out  1  force tx electrical idle.
txdata_in  in  32  link-layer tx data.
txcharisk_in  in  4  link-layer tx K flags.
txdata_out  out  32  data to GTX.
txcharisk_out  out  4  K flags to GTX.
rxdata_in  in  32  data from GTX.
rxcharisk_in  in  4  K flags from GTX.
rxbyteisaligned  in  1  comma alignment achieved.
dev_reset  out  1  1-cycle pulse on each accepted COMRESET.
phy_ready  out  1  link up.

Behaviour:
- Interface: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: txelecidle=1; txcominit, txcomwake, dev_reset, phy_ready = 0; txdata_out=0; txcharisk_out=0. State=IDLE. Timer=0.
- Constants:
  - ALIGN = 0x7B4A4ABC, charisk 4'b0001.
  - SYNC = 0xB5B5957C, charisk 4'b0001.
- "rx ALIGN" means rxbyteisaligned=1, rxdata_in=ALIGN and rxcharisk_in=4'b0001.
- Control outputs are Moore-decoded from the state register. txdata_out and txcharisk_out are registered (1-cycle latency).
- States and transitions:
  - IDLE: txelecidle=1. On rxcominitdet_in=1 -> COMINIT, with a dev_reset pulse in the cycle COMINIT is entered.
  - COMINIT: txcominit=1 for exactly 1 cycle -> WAIT_CINIT.
  - WAIT_CINIT: on txcomfinish -> WAIT_WAKE, timer cleared.
  - WAIT_WAKE: on rxcomwakedet_in -> WAIT_WAKE_END. If timer reaches COMWAKE_TIMEOUT -> ERROR.
  - WAIT_WAKE_END: on rxcomwakedet_in=0 -> COMWAKE.
  - COMWAKE: txcomwake=1 for 1 cycle -> WAIT_CWAKE.
  - WAIT_CWAKE: on txcomfinish -> SEND_ALIGN, timer cleared.
  - SEND_ALIGN: txelecidle=0, transmit ALIGN every cycle. On rx ALIGN -> SEND_SYNC. If timer reaches ALIGN_TIMEOUT -> ERROR.
  - SEND_SYNC: transmit SYNC. Count consecutive rx words with rxcharisk_in[0]=1 and data != ALIGN; any other word clears the count. When the count reaches 3 -> READY.
  - READY: phy_ready=1; txdata_out/txcharisk_out = txdata_in/txcharisk_in delayed 1 cycle.
  - ERROR: txelecidle=1 for 1 cycle -> IDLE.
- Priority of events, highest first:
  - rst.
  - gtx_ready=0 -> IDLE from any state (no dev_reset).
  - rxcominitdet_in=1 in any state other than COMINIT or WAIT_CINIT -> COMINIT with a dev_reset pulse. This covers READY and mid-handshake.
  - Normal transitions.
- txelecidle=1 in every state except SEND_ALIGN, SEND_SYNC and READY. In those states txdata_out=0 and txcharisk_out=0.
- Timer: 20 bits, saturating. Increments only in WAIT_WAKE and SEND_ALIGN; cleared on every state change.
- phy_ready drops in the same cycle the state leaves READY.

Test Plan:
- Normal bring-up:
  - Stimulus: reset, gtx_ready=1; rxcominitdet pulse; txcomfinish 20 cycles after txcominit; rxcomwakedet high 10 cycles; txcomfinish; then rx ALIGN; then 3 SYNC words.
  - Required: dev_reset and txcominit each seen once; txcomwake asserted 1 cycle after rxcomwakedet falls; ALIGN on txdata_out; SYNC after rx ALIGN; phy_ready=1 after the 3rd SYNC; txdata_in=0x12345678 appears on txdata_out 1 cycle later.
- COMWAKE timeout:
  - Stimulus: COMINIT completes, then no rxcomwakedet.
  - Required: ERROR after 66000 cycles in WAIT_WAKE; txelecidle stays 1; back to IDLE; phy_ready never set.
- ALIGN timeout:
  - Stimulus: reach SEND_ALIGN, feed 0x4A4A4A4A with charisk 0.
  - Required: ALIGN transmitted for 66000 cycles, then txelecidle=1 and IDLE.
- SYNC count reset:
  - Stimulus: in SEND_SYNC feed SYNC, SYNC, ALIGN, SYNC, SYNC, SYNC.
  - Required: phy_ready rises only after the final 3rd consecutive SYNC.
- COMRESET in READY:
  - Stimulus: rxcominitdet while phy_ready=1.
  - Required: next cycle phy_ready=0, txelecidle=1, dev_reset=1, txcominit=1 the cycle after.
- gtx_ready drop mid-handshake:
  - Stimulus: gtx_ready=0 during SEND_ALIGN.
  - Required: IDLE next cycle; txelecidle=1; no dev_reset pulse.
